draw_sprite_anim: RTL and testbench
===================================

# draw_sprite_anim

Parametrised animated-sprite address generator for the VGA sprite pipeline. It stores an N-frame animation strip in sprite ROM, steps through the frames on a programmable number of frame ticks, and latches the sprite position once per frame so a moving sprite does not tear. It also produces the per-pixel `sprite_on` flag and the ROM read address for the frame-buffer writer. It generalises the fixed two-frame runner drawer so that dino, bird, and cactus sprites share one block.

## Interface
- `SPRITE_W`, default 88: sprite width in pixels.
- `SPRITE_H`, default 94: sprite height in pixels.
- `NUM_FRAMES`, default 2: animation frames in the strip, 1..16.
- `FRAME_BASE`, default 207867: ROM address of pixel (0,0) of frame 0.
- `FRAME_STRIDE`, default `SPRITE_W*SPRITE_H`: ROM distance between consecutive frames.
- `HOLD_TICKS`, default 10: frame ticks each animation frame is shown, ≥1.
- `ADDR_W`, default 18: ROM address width.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `Clk`  in  1  pixel clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-`Clk` pulse at each vertical blank, synchronous to `Clk`.
- `anim_en`  in  1  1 = advance animation on ticks; 0 = freeze the current frame.
- `restart`  in  1  one-cycle pulse; returns the animation to frame 0.
- `flip_h`  in  1  horizontal mirror request; used only with the macro below.
- `PosX`, `PosY`  in  10 each  requested top-left corner of the sprite on screen.
- `DrawX`, `DrawY`  in  10 each  scan position used for `sprite_on`.
- `WriteX`, `WriteY`  in  10 each  write position used for `address`.
- `sprite_on`  out  1  scan point lies inside the sprite box.
- `address`  out  `ADDR_W`  ROM address for the write point.
- `anim_idx`  out  4  current frame index.

## Operation
- Registers:
  - `hold_cnt`: counts 0..HOLD_TICKS-1.
  - `anim_idx`: counts 0..NUM_FRAMES-1.
  - `frame_start`: equals FRAME_BASE + anim_idx*FRAME_STRIDE. It is kept incrementally (add FRAME_STRIDE on advance, load FRAME_BASE on wrap), so no multiplier is needed for it.
  - `pos_x_q`, `pos_y_q`: latched position.
- Position latch:
  - Loads `PosX`/`PosY` on every `frame_tick`, regardless of `anim_en`.
  - All box and offset math uses the latched values.
- Animation state machine, evaluated only on a `frame_tick` cycle, highest priority first:
  - RESTART (`restart`=1): `hold_cnt`←0, `anim_idx`←0, `frame_start`←FRAME_BASE.
  - FREEZE (`anim_en`=0): no change.
  - HOLD (`hold_cnt` < HOLD_TICKS-1): `hold_cnt`++.
  - ADVANCE: `hold_cnt`←0, then:
    - if `anim_idx`=NUM_FRAMES-1, wrap to 0 and load FRAME_BASE;
    - else `anim_idx`++ and `frame_start` += FRAME_STRIDE.
- `restart` without a tick:
  - Applies the RESTART action on that cycle.
  - `restart` always wins over a simultaneous advance.
- With NUM_FRAMES=1, `anim_idx` stays 0 and `frame_start` stays FRAME_BASE.
- Box test: `sprite_on` = DrawX∈[pos_x_q, pos_x_q+SPRITE_W) and DrawY∈[pos_y_q, pos_y_q+SPRITE_H).
  - Compare in 11 bits so that PosX+SPRITE_W > 1023 does not wrap.
- Address calculation:
  - dx = WriteX−pos_x_q, dy = WriteY−pos_y_q.
  - `address` = frame_start + dy*SPRITE_W + dx, truncated to ADDR_W bits.
  - When the write point is outside the box, `address` = frame_start (offset forced to 0). No out-of-strip ROM reads occur.

## Timing
- Values after `Reset`: `anim_idx`=0, `hold_cnt`=0, `frame_start`=FRAME_BASE, `pos_*_q`=0, `sprite_on`=0, `address`=0.
- `sprite_on` and `address` are registered: one `Clk` of latency from DrawX/DrawY/WriteX/WriteY.
- A tick at edge n affects outputs computed from inputs at edge n+1:
  - the new `anim_idx` and latched position are visible at edge n+1;
  - outputs reflect them at edge n+2.
- `Reset` mid-animation: all state returns to reset values on the next edge; the tick on that cycle is ignored.

## Configuration
- `SPRITE_MIRROR_EN` defined:
  - With `flip_h`=1, the column becomes SPRITE_W−1−dx; rows are unchanged.
  - `flip_h` is sampled with the position latch on `frame_tick`.
- `SPRITE_MIRROR_EN` undefined: `flip_h` is ignored and no mirror logic is built.

## Test plan
- Reset, then PosX=100, PosY=200, one tick. WriteX=100, WriteY=200 → `address`=207867 one cycle later. WriteX=187, WriteY=293 → 207867+93*88+87=216138.
- `anim_en`=1 with 10 ticks → `anim_idx`=1 and `address` at (0,0) offset = 216139. 20 ticks total → wraps to `anim_idx`=0 and 207867.
- `anim_en`=0 for 30 ticks → `anim_idx` unchanged. `restart` together with the 10th tick → `anim_idx`=0 and `hold_cnt`=0.
- Scan DrawX=99/100/187/188 at DrawY=250 → `sprite_on` 0/1/1/0. With PosX=1000: DrawX=1023 → 1, and no wrap at DrawX=0.
- Change PosX between ticks → `sprite_on` box moves only after the next tick. WriteX outside the box → `address`=frame_start.
- With SPRITE_MIRROR_EN, `flip_h`=1: write point (pos_x_q, pos_y_q) → FRAME_BASE+87. Without the macro → FRAME_BASE.

Source files
------------

// File: rtl/draw_sprite_anim.sv
// Animated sprite address generator: frame stepping, per-frame position latch, box test and ROM address.
// Outputs registered (1 Clk latency); no backpressure. Optional horizontal mirror under SPRITE_MIRROR_EN.
module draw_sprite_anim #(
  parameter int SPRITE_W     = 88,
  parameter int SPRITE_H     = 94,
  parameter int NUM_FRAMES   = 2,
  parameter int FRAME_BASE   = 207867,
  parameter int FRAME_STRIDE = SPRITE_W * SPRITE_H,
  parameter int HOLD_TICKS   = 10,
  parameter int ADDR_W       = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              anim_en,
  input  logic              restart,
  input  logic              flip_h,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        WriteX,
  input  logic [9:0]        WriteY,
  output logic              sprite_on,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        anim_idx
);

  localparam logic [15:0]       HOLD_LAST   = 16'(HOLD_TICKS - 1);
  localparam logic [3:0]        IDX_LAST    = 4'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(FRAME_STRIDE);
  localparam logic [ADDR_W-1:0] SPRITE_W_A  = ADDR_W'(SPRITE_W);
  localparam logic [10:0]       SPRITE_W_11 = 11'(SPRITE_W);
  localparam logic [10:0]       SPRITE_H_11 = 11'(SPRITE_H);

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RESTART,
    ACT_HOLD,
    ACT_ADVANCE
  } act_t;

  act_t              act;
  logic [15:0]       hold_cnt, hold_nxt;
  logic [3:0]        idx_nxt;
  logic [ADDR_W-1:0] frame_start, start_nxt;
  logic [9:0]        pos_x_q, pos_y_q;
  logic [9:0]        dx, dy, col;
  logic [ADDR_W-1:0] offset;
  logic              in_scan, in_write;

  // restart is honoured with or without a tick and beats any advance
  always_comb begin
    act       = ACT_NONE;
    hold_nxt  = hold_cnt;
    idx_nxt   = anim_idx;
    start_nxt = frame_start;
    if (restart)
      act = ACT_RESTART;
    else if (frame_tick && anim_en)
      act = (hold_cnt < HOLD_LAST) ? ACT_HOLD : ACT_ADVANCE;
    case (act)
      ACT_RESTART: begin
        hold_nxt  = '0;
        idx_nxt   = '0;
        start_nxt = BASE_A;
      end
      ACT_HOLD: hold_nxt = hold_cnt + 16'd1;
      ACT_ADVANCE: begin
        hold_nxt = '0;
        if (anim_idx >= IDX_LAST) begin
          idx_nxt   = '0;
          start_nxt = BASE_A;
        end else begin
          idx_nxt   = anim_idx + 4'd1;
          start_nxt = frame_start + STRIDE_A;
        end
      end
      default: ;
    endcase
  end

  // 11-bit box compares keep PosX+SPRITE_W from wrapping past the screen edge
  always_comb begin
    in_scan  = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
               ({1'b0, DrawX} <  ({1'b0, pos_x_q} + SPRITE_W_11)) &&
               ({1'b0, DrawY} >= {1'b0, pos_y_q}) &&
               ({1'b0, DrawY} <  ({1'b0, pos_y_q} + SPRITE_H_11));
    in_write = ({1'b0, WriteX} >= {1'b0, pos_x_q}) &&
               ({1'b0, WriteX} <  ({1'b0, pos_x_q} + SPRITE_W_11)) &&
               ({1'b0, WriteY} >= {1'b0, pos_y_q}) &&
               ({1'b0, WriteY} <  ({1'b0, pos_y_q} + SPRITE_H_11));
  end

  assign dx = WriteX - pos_x_q;
  assign dy = WriteY - pos_y_q;

`ifdef SPRITE_MIRROR_EN
  logic flip_q;
  assign col = flip_q ? (10'(SPRITE_W - 1) - dx) : dx;
`else
  logic unused_flip;
  assign unused_flip = flip_h;
  assign col = dx;
`endif

  assign offset = ADDR_W'(dy) * SPRITE_W_A + ADDR_W'(col);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt    <= '0;
      anim_idx    <= '0;
      frame_start <= BASE_A;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      sprite_on   <= 1'b0;
      address     <= '0;
`ifdef SPRITE_MIRROR_EN
      flip_q      <= 1'b0;
`endif
    end else begin
      hold_cnt    <= hold_nxt;
      anim_idx    <= idx_nxt;
      frame_start <= start_nxt;
      if (frame_tick) begin
        pos_x_q <= PosX;
        pos_y_q <= PosY;
`ifdef SPRITE_MIRROR_EN
        flip_q  <= flip_h;
`endif
      end
      sprite_on <= in_scan;
      // outside the box the offset is dropped so reads stay inside the strip
      address   <= in_write ? (frame_start + offset) : frame_start;
    end
  end

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Directed bench for draw_sprite_anim with default parameters.
module tb_draw_sprite_anim;

  localparam int FB = 207867;

  logic        Clk = 1'b0;
  logic        Reset, frame_tick, anim_en, restart, flip_h;
  logic [9:0]  PosX, PosY, DrawX, DrawY, WriteX, WriteY;
  logic        sprite_on;
  logic [17:0] address;
  logic [3:0]  anim_idx;

  int vectors = 0;
  int miscompares = 0;

  draw_sprite_anim dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .anim_en(anim_en),
    .restart(restart), .flip_h(flip_h), .PosX(PosX), .PosY(PosY),
    .DrawX(DrawX), .DrawY(DrawY), .WriteX(WriteX), .WriteY(WriteY),
    .sprite_on(sprite_on), .address(address), .anim_idx(anim_idx)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input int wx, input int wy, input int exp);
    WriteX = 10'(wx);
    WriteY = 10'(wy);
    step();
    chk(tag, 32'(address), 32'(exp));
  endtask

  task automatic chk_on(input string tag, input int x, input int y, input logic exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    chk(tag, 32'(sprite_on), 32'(exp));
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; anim_en = 1'b0; restart = 1'b0; flip_h = 1'b0;
    PosX = '0; PosY = '0; DrawX = '0; DrawY = '0; WriteX = '0; WriteY = '0;
    step(); step();
    chk("rst_sprite_on", 32'(sprite_on), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_anim_idx", 32'(anim_idx), 32'd0);
    Reset = 1'b0;
    chk_addr("rst_pos_addr", 0, 0, FB);
    chk_on("rst_pos_on", 0, 0, 1'b1);

    // first placement, animation frozen
    PosX = 10'd100; PosY = 10'd200;
    ticks(1);
    chk_addr("addr_origin", 100, 200, FB);
    chk_addr("addr_corner", 187, 293, 216138);
    chk_on("scan_99", 99, 250, 1'b0);
    chk_on("scan_100", 100, 250, 1'b1);
    chk_on("scan_187", 187, 250, 1'b1);
    chk_on("scan_188", 188, 250, 1'b0);
    chk_on("scan_y199", 150, 199, 1'b0);
    chk_on("scan_y293", 150, 293, 1'b1);
    chk_on("scan_y294", 150, 294, 1'b0);
    chk_addr("out_right", 188, 250, FB);
    chk_addr("out_left", 50, 250, FB);

    // stepping
    anim_en = 1'b1;
    ticks(9);
    chk("hold_9", 32'(anim_idx), 32'd0);
    ticks(1);
    chk("adv_10", 32'(anim_idx), 32'd1);
    chk_addr("f1_origin", 100, 200, 216139);
    chk_addr("f1_corner", 187, 293, 224410);
    ticks(10);
    chk("wrap_20", 32'(anim_idx), 32'd0);
    chk_addr("wrap_origin", 100, 200, FB);

    // freeze, then restart on a tick mid-hold
    ticks(10);
    chk("adv_again", 32'(anim_idx), 32'd1);
    anim_en = 1'b0;
    ticks(30);
    chk("freeze_30", 32'(anim_idx), 32'd1);
    anim_en = 1'b1;
    ticks(5);
    restart = 1'b1;
    ticks(1);
    restart = 1'b0;
    chk("restart_tick_idx", 32'(anim_idx), 32'd0);
    chk_addr("restart_tick_addr", 100, 200, FB);
    ticks(9);
    chk("restart_hold_clr", 32'(anim_idx), 32'd0);
    ticks(1);
    chk("restart_then_adv", 32'(anim_idx), 32'd1);
    chk_addr("out_f1", 50, 250, 216139);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_notick", 32'(anim_idx), 32'd0);
    chk_addr("restart_notick_addr", 100, 200, FB);

    // position moves only on a tick
    anim_en = 1'b0;
    PosX = 10'd300;
    chk_on("move_pre_new", 300, 250, 1'b0);
    chk_on("move_pre_old", 150, 250, 1'b1);
    ticks(1);
    chk_on("move_post_new", 300, 250, 1'b1);
    chk_on("move_post_old", 150, 250, 1'b0);

    // right screen edge
    PosX = 10'd1000;
    ticks(1);
    chk_on("edge_1023", 1023, 250, 1'b1);
    chk_on("edge_nowrap_0", 0, 250, 1'b0);
    chk_on("edge_999", 999, 250, 1'b0);

    // mirror
    PosX = 10'd100; flip_h = 1'b1;
    ticks(1);
    flip_h = 1'b0;
`ifdef SPRITE_MIRROR_EN
    chk_addr("mirror_left", 100, 200, FB + 87);
    chk_addr("mirror_right", 187, 200, FB);
`else
    chk_addr("nomirror_left", 100, 200, FB);
    chk_addr("nomirror_right", 187, 200, FB + 87);
`endif

    // reset mid-animation with a simultaneous tick
    anim_en = 1'b1;
    ticks(3);
    Reset = 1'b1; frame_tick = 1'b1;
    step();
    Reset = 1'b0; frame_tick = 1'b0;
    chk("midrst_idx", 32'(anim_idx), 32'd0);
    chk("midrst_on", 32'(sprite_on), 32'd0);
    chk("midrst_addr", 32'(address), 32'd0);
    chk_addr("midrst_pos_addr", 0, 0, FB);
    chk_on("midrst_pos_on", 0, 0, 1'b1);
    ticks(9);
    chk("midrst_hold", 32'(anim_idx), 32'd0);
    ticks(1);
    chk("midrst_adv", 32'(anim_idx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
